// File: rtl/v_dsampler_pkg.sv
// Shared helpers and constants for the AXI4-Stream video decimator.
// Module parameters feed the derivation functions here to size counters and buses.
package v_dsampler_pkg;

  localparam int DEF_PPC         = 8;
  localparam int DEF_PIXEL_WIDTH = 24;
  localparam int DEF_H_FACTOR    = 2;
  localparam int DEF_V_FACTOR    = 2;
  localparam int DEF_LINE_CNT_W  = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Counter width that is never zero, so a factor of 1 still gets a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int keep_per_beat(input int ppc, input int h_factor);
    return ppc / h_factor;
  endfunction

  function automatic int data_w(input int ppc, input int pixel_width);
    return ppc * pixel_width;
  endfunction

  function automatic bit cfg_ok(input int ppc, input int h_factor, input int v_factor);
    return is_pow2(ppc) && (ppc <= 8) &&
           is_pow2(h_factor) && (h_factor <= 4) && (h_factor <= ppc) &&
           is_pow2(v_factor) && (v_factor <= 4);
  endfunction

endpackage

// File: rtl/v_dsampler_hpack.sv
// Horizontal lane select and pack accumulator: merges kept pixels of up to
// H_FACTOR input beats into one full-width beat, tracked by beat_idx.
module v_dsampler_hpack
  import v_dsampler_pkg::*;
#(
  parameter int PPC         = DEF_PPC,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int H_FACTOR    = DEF_H_FACTOR
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           i_valid,
  input  logic                           i_clear,
  input  logic [PPC*PIXEL_WIDTH-1:0]     i_data,
  input  logic                           i_last,
  output logic [PPC*PIXEL_WIDTH-1:0]     o_pack_data,
  output logic                           o_pack_done,
  output logic                           o_pack_last
);

  localparam int KPB    = keep_per_beat(PPC, H_FACTOR);
  localparam int DATA_W = data_w(PPC, PIXEL_WIDTH);
  localparam int CW     = cnt_w(H_FACTOR);
  localparam logic [CW-1:0] LAST_IDX = CW'(H_FACTOR - 1);

  logic [CW-1:0]     r_beat_idx;
  logic [CW-1:0]     w_beat_idx;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_base;
  logic [DATA_W-1:0] w_pack;
  logic              w_unused_data;

  // A start-of-frame beat discards any partial group before its own pixels land.
  assign w_beat_idx = i_clear ? '0 : r_beat_idx;
  assign w_base     = i_clear ? '0 : r_acc;

  always_comb begin
    w_pack = w_base;
    for (int k = 0; k < H_FACTOR; k++) begin
      for (int j = 0; j < KPB; j++) begin
        if (w_beat_idx == CW'(k)) begin
          w_pack[(k*KPB+j)*PIXEL_WIDTH +: PIXEL_WIDTH] =
            i_data[j*H_FACTOR*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
      end
    end
  end

  assign o_pack_data = w_pack;
  assign o_pack_done = i_valid && ((w_beat_idx == LAST_IDX) || i_last);
  assign o_pack_last = i_valid && i_last;

  // Dropped pixels are deliberately ignored.
  assign w_unused_data = ^i_data;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_acc      <= '0;
      r_beat_idx <= '0;
    end else if (o_pack_done || (i_clear && !i_valid)) begin
      r_acc      <= '0;
      r_beat_idx <= '0;
    end else if (i_valid) begin
      r_acc      <= w_pack;
      r_beat_idx <= w_beat_idx + CW'(1);
    end
  end

endmodule

// File: rtl/v_dsampler_axis.sv
// AXI4-Stream video decimator: drops V_FACTOR-1 of every V_FACTOR lines and
// keeps every H_FACTOR-th pixel, repacking survivors into full-width beats.
module v_dsampler_axis
  import v_dsampler_pkg::*;
#(
  parameter int PPC         = DEF_PPC,
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int H_FACTOR    = DEF_H_FACTOR,
  parameter int V_FACTOR    = DEF_V_FACTOR,
  parameter int LINE_CNT_W  = DEF_LINE_CNT_W
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [PPC*PIXEL_WIDTH-1:0]   s_axis_tdata,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [PPC*PIXEL_WIDTH-1:0]   m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser
);

  localparam int DATA_W = data_w(PPC, PIXEL_WIDTH);
  localparam logic [LINE_CNT_W-1:0] V_MASK = LINE_CNT_W'(V_FACTOR - 1);

  if (!cfg_ok(PPC, H_FACTOR, V_FACTOR)) begin : g_bad_cfg
    $error("v_dsampler_axis: illegal PPC/H_FACTOR/V_FACTOR combination");
  end

  logic                  r_valid;
  logic                  r_last;
  logic                  r_user;
  logic [DATA_W-1:0]     r_data;
  logic [LINE_CNT_W-1:0] r_line_idx;
  logic                  r_sof_pend;

  logic                  w_accept;
  logic                  w_sof_beat;
  logic [LINE_CNT_W-1:0] w_line_eff;
  logic                  w_keep;
  logic                  w_pack_in;
  logic [DATA_W-1:0]     w_pack_data;
  logic                  w_pack_done;
  logic                  w_pack_last;
  logic                  w_sof_eff;

  // Valid/ready: a beat moves when tvalid & tready are both high at a clock edge.
  // tvalid never depends on tready; once raised, tvalid/tdata/tlast/tuser hold
  // until taken. The input is ready whenever the single output slot is empty or
  // being drained this cycle, so a completed pack always has somewhere to go.
  assign s_axis_tready = !r_valid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_sof_beat    = w_accept && s_axis_tuser;

  assign w_line_eff = s_axis_tuser ? '0 : r_line_idx;
  assign w_keep     = (w_line_eff == '0);
  assign w_pack_in  = w_accept && w_keep;
  assign w_sof_eff  = r_sof_pend || w_sof_beat;

  v_dsampler_hpack #(
    .PPC         (PPC),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .H_FACTOR    (H_FACTOR)
  ) u_hpack (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .i_valid     (w_pack_in),
    .i_clear     (w_sof_beat),
    .i_data      (s_axis_tdata),
    .i_last      (s_axis_tlast),
    .o_pack_data (w_pack_data),
    .o_pack_done (w_pack_done),
    .o_pack_last (w_pack_last)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_line_idx <= '0;
    end else if (w_accept && s_axis_tlast) begin
      r_line_idx <= (w_line_eff + LINE_CNT_W'(1)) & V_MASK;
    end else if (w_sof_beat) begin
      r_line_idx <= '0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sof_pend <= 1'b0;
    end else if (w_pack_done) begin
      r_sof_pend <= 1'b0;
    end else if (w_sof_beat) begin
      r_sof_pend <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_user  <= 1'b0;
    end else if (w_pack_done) begin
      r_valid <= 1'b1;
      r_data  <= w_pack_data;
      r_last  <= w_pack_last;
      r_user  <= w_sof_eff;
    end else if (m_axis_tready) begin
      r_valid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata  = r_data;
  assign m_axis_tlast  = r_last;
  assign m_axis_tuser  = r_user;

endmodule

// File: tb/tb_v_dsampler_axis.sv
// Bench for v_dsampler_axis: three configurations (8ppc H2 V2, 4ppc H4 V1, 8ppc H1 V1)
// share one input stream and are each checked against a frame-level model.
module tb_v_dsampler_axis;

  localparam int PW = 24;
  localparam int W  = 192;
  localparam int EW = W + 2;

  // clock/reset
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic           s_valid [3];
  logic           s_ready [3];
  logic [W-1:0]   s_data;
  logic           s_last;
  logic           s_user;
  logic           m_valid [3];
  logic           m_ready [3] = '{1'b1, 1'b1, 1'b1};
  logic           m_last  [3];
  logic           m_user  [3];
  logic [W-1:0]   m_data_a;
  logic [95:0]    m_data_b;
  logic [W-1:0]   m_data_c;
  logic [W-1:0]   m_data  [3];

  assign m_data[0] = m_data_a;
  assign m_data[1] = {96'd0, m_data_b};
  assign m_data[2] = m_data_c;

  v_dsampler_axis #(.PPC(8), .PIXEL_WIDTH(PW), .H_FACTOR(2), .V_FACTOR(2), .LINE_CNT_W(16)) u_dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]), .m_axis_tdata(m_data_a),
    .m_axis_tlast(m_last[0]), .m_axis_tuser(m_user[0]));

  v_dsampler_axis #(.PPC(4), .PIXEL_WIDTH(PW), .H_FACTOR(4), .V_FACTOR(1), .LINE_CNT_W(16)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]), .s_axis_tdata(s_data[95:0]),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]), .m_axis_tdata(m_data_b),
    .m_axis_tlast(m_last[1]), .m_axis_tuser(m_user[1]));

  v_dsampler_axis #(.PPC(8), .PIXEL_WIDTH(PW), .H_FACTOR(1), .V_FACTOR(1), .LINE_CNT_W(16)) u_dut_c (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid[2]), .s_axis_tready(s_ready[2]), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready[2]), .m_axis_tdata(m_data_c),
    .m_axis_tlast(m_last[2]), .m_axis_tuser(m_user[2]));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;

  int cfg_ppc [3] = '{8, 4, 8};
  int cfg_h   [3] = '{2, 4, 1};
  int cfg_v   [3] = '{2, 1, 1};

  // model state: line number in frame, beats in current group, pending start of frame
  int           md_line [3];
  int           md_n    [3];
  bit           md_sof  [3];
  logic [W-1:0] md_buf  [3];

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];

  int            out_cnt  [3];
  int            n_user   [3];
  int            n_last   [3];
  logic [EW-1:0] first_out[3];
  logic [EW-1:0] last_out [3];

  function automatic void check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(int i, logic [EW-1:0] e);
    case (i)
      0: exp_q0.push_back(e);
      1: exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [EW-1:0] pop_exp(int i);
    case (i)
      0: return exp_q0.pop_front();
      1: return exp_q1.pop_front();
      default: return exp_q2.pop_front();
    endcase
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      md_line[i] = 0;
      md_n[i]    = 0;
      md_sof[i]  = 1'b0;
      md_buf[i]  = '0;
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endfunction

  // Frame-level rules: keep every V-th line of a frame, every H-th pixel of a beat,
  // ship a beat once H beats are gathered or the line ends.
  function automatic void model_accept(int i, logic [W-1:0] d, logic l, logic u);
    int           kpb;
    logic [W-1:0] b;
    kpb = cfg_ppc[i] / cfg_h[i];
    if (u) begin
      md_line[i] = 0;
      md_sof[i]  = 1'b1;
      md_buf[i]  = '0;
      md_n[i]    = 0;
    end
    if ((md_line[i] % cfg_v[i]) == 0) begin
      b = md_buf[i];
      for (int j = 0; j < kpb; j++) b[(md_n[i]*kpb + j)*PW +: PW] = d[j*cfg_h[i]*PW +: PW];
      md_buf[i] = b;
      md_n[i]++;
      if (md_n[i] == cfg_h[i] || l) begin
        push_exp(i, {md_sof[i], l, md_buf[i]});
        md_sof[i] = 1'b0;
        md_buf[i] = '0;
        md_n[i]   = 0;
      end
    end
    if (l) md_line[i] = (md_line[i] + 1) % cfg_v[i];
  endfunction

  function automatic logic [W-1:0] lanes_step(int start, int step, int n);
    logic [W-1:0] d;
    d = '0;
    for (int j = 0; j < n; j++) d[j*PW +: PW] = PW'(start + step*j);
    return d;
  endfunction

  function automatic logic [W-1:0] col_beat(int b);
    return lanes_step(8*b, 1, 8);
  endfunction

  // downstream ready pattern
  always @(negedge aclk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) m_ready[i] = (rdy_mode == 0) ? 1'b1 : cyc[0];
  end

  // scoreboard compare process
  logic [EW-1:0] prev_w     [3];
  bit            prev_stall [3];
  always @(negedge aclk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    #2;
    for (int i = 0; i < 3; i++) begin
      if (!aresetn) begin
        prev_stall[i] = 1'b0;
      end else begin
        act = {m_user[i], m_last[i], m_data[i]};
        check($sformatf("tready_rule_%0d", i), EW'(s_ready[i]), EW'(!m_valid[i] || m_ready[i]));
        if (prev_stall[i]) begin
          check($sformatf("hold_valid_%0d", i), EW'(m_valid[i]), EW'(1));
          check($sformatf("hold_word_%0d", i), act, prev_w[i]);
        end
        if (m_valid[i] && m_ready[i]) begin
          if (q_size(i) == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected_%0d: got %h, required no beat", i, act);
          end else begin
            e = pop_exp(i);
            check($sformatf("out_beat_%0d", i), act, e);
          end
          if (out_cnt[i] == 0) first_out[i] = act;
          out_cnt[i]++;
          last_out[i] = act;
          if (m_user[i]) n_user[i]++;
          if (m_last[i]) n_last[i]++;
        end
        prev_stall[i] = m_valid[i] && !m_ready[i];
        prev_w[i]     = act;
      end
    end
  end

  // driver tasks
  task automatic clear_stats();
    for (int i = 0; i < 3; i++) begin
      out_cnt[i]   = 0;
      n_user[i]    = 0;
      n_last[i]    = 0;
      first_out[i] = '0;
      last_out[i]  = '0;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l, input logic u);
    logic [2:0] pend;
    int         budget;
    pend   = 3'b111;
    budget = 0;
    while (pend != 3'b000 && budget < 200) begin
      @(negedge aclk);
      s_data = d;
      s_last = l;
      s_user = u;
      for (int i = 0; i < 3; i++) s_valid[i] = pend[i];
      #1;
      for (int i = 0; i < 3; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          model_accept(i, d, l, u);
          pend[i] = 1'b0;
        end
      end
      @(posedge aclk);
      budget++;
    end
    if (pend != 3'b000) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: pending %b, required 000", pend);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge aclk);
      for (int i = 0; i < 3; i++) s_valid[i] = 1'b0;
      s_last = 1'b0;
      s_user = 1'b0;
    end
    #3;
    for (int i = 0; i < 3; i++) check($sformatf("queue_empty_%0d", i), EW'(q_size(i)), EW'(0));
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    for (int i = 0; i < 3; i++) s_valid[i] = 1'b0;
    model_clear();
    @(posedge aclk);
    @(negedge aclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_valid_%0d", i), EW'(m_valid[i]), EW'(0));
      check($sformatf("rst_word_%0d", i), {m_user[i], m_last[i], m_data[i]}, EW'(0));
    end
    aresetn = 1'b1;
  endtask

  task automatic send_frame(input int lines, input int beats);
    for (int ln = 0; ln < lines; ln++)
      for (int b = 0; b < beats; b++)
        send_beat(col_beat(b), b == beats - 1, ln == 0 && b == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    s_user  = 1'b0;
    for (int i = 0; i < 3; i++) s_valid[i] = 1'b0;
    model_clear();
    clear_stats();
    do_reset();

    // 1920x4 frame, free-running output
    clear_stats();
    send_frame(4, 240);
    drain(10);
    check("t1_cnt_a", EW'(out_cnt[0]), EW'(240));
    check("t1_last_a", EW'(n_last[0]), EW'(2));
    check("t1_user_a", EW'(n_user[0]), EW'(1));
    check("t1_first_a", first_out[0], {2'b10, lanes_step(0, 2, 8)});
    check("t1_cnt_b", EW'(out_cnt[1]), EW'(240));
    check("t1_cnt_c", EW'(out_cnt[2]), EW'(960));

    // same frame with toggling downstream ready
    rdy_mode = 1;
    clear_stats();
    send_frame(4, 240);
    drain(10);
    rdy_mode = 0;
    drain(2);
    check("t2_cnt_a", EW'(out_cnt[0]), EW'(240));
    check("t2_last_a", EW'(n_last[0]), EW'(2));
    check("t2_first_a", first_out[0], {2'b10, lanes_step(0, 2, 8)});
    check("t2_cnt_c", EW'(out_cnt[2]), EW'(960));

    // 10-beat line: short final group on the 4ppc H4 instance
    clear_stats();
    send_frame(1, 10);
    drain(10);
    check("t3_cnt_b", EW'(out_cnt[1]), EW'(3));
    check("t3_tail_b", last_out[1], {2'b01, lanes_step(64, 8, 2)});
    check("t3_cnt_a", EW'(out_cnt[0]), EW'(5));
    check("t3_tail_c", last_out[2], {2'b01, col_beat(9)});

    // tuser arriving at beat 37 of line 1
    clear_stats();
    for (int b = 0; b < 240; b++) send_beat(col_beat(b), b == 239, b == 0);
    for (int b = 0; b < 37; b++) send_beat(col_beat(b), 1'b0, 1'b0);
    send_beat(col_beat(0), 1'b0, 1'b1);
    send_beat(col_beat(1), 1'b1, 1'b0);
    drain(10);
    check("t4_cnt_a", EW'(out_cnt[0]), EW'(121));
    check("t4_new_a", last_out[0], {2'b11, lanes_step(0, 2, 8)});
    check("t4_cnt_b", EW'(out_cnt[1]), EW'(70));
    check("t4_new_b", last_out[1], {2'b11, lanes_step(0, 8, 2)});

    // reset with a half-filled group
    send_beat(col_beat(5), 1'b0, 1'b1);
    do_reset();
    clear_stats();
    send_beat(col_beat(20), 1'b0, 1'b0);
    send_beat(col_beat(21), 1'b1, 1'b0);
    drain(10);
    check("t5_cnt_a", EW'(out_cnt[0]), EW'(1));
    check("t5_word_a", last_out[0], {2'b01, lanes_step(160, 2, 8)});
    check("t5_word_b", last_out[1], {2'b01, lanes_step(160, 8, 2)});

    // one beat with tuser and tlast together; one-cycle latency
    clear_stats();
    send_beat(col_beat(3), 1'b1, 1'b1);
    @(negedge aclk);
    for (int i = 0; i < 3; i++) s_valid[i] = 1'b0;
    #1;
    check("t6_valid_c", EW'(m_valid[2]), EW'(1));
    check("t6_word_c", {m_user[2], m_last[2], m_data[2]}, {2'b11, col_beat(3)});
    check("t6_valid_a", EW'(m_valid[0]), EW'(1));
    check("t6_word_a", {m_user[0], m_last[0], m_data[0]}, {2'b11, lanes_step(24, 2, 4)});
    check("t6_word_b", {m_user[1], m_last[1], m_data[1]}, {2'b11, lanes_step(24, 8, 1)});
    drain(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
